// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for the multicycle MIPS core. Sequences
//               fetch/decode/execute/memory/writeback, drives every datapath
//               select and write enable, and stalls on memory wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next;
  // Opcode is only looked at in DECODE, so MEMADR needs a remembered lw/sw flag.
  logic   r_is_store;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Capture the load/store distinction while the opcode is valid in DECODE.
  always_ff @(posedge clk) begin
    if (reset)                  r_is_store <= 1'b0;
    else if (r_state == S_DECODE) r_is_store <= (opcode == c_OP_SW);
  end

  // Next-state and output decode; reset gates enables and shows FETCH selects.
  always_comb begin
    w_next     = S_FETCH;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          c_OP_RTYPE:      w_next = S_EXECUTE;
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_BEQ:        w_next = S_BRANCH;
          c_OP_ADDI:       w_next = S_ADDIEX;
          c_OP_J:          w_next = S_JUMP;
          default: begin
            w_next  = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = r_is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        w_next    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: w_next = S_FETCH;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      i_or_d     = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      alu_op     = 2'b00;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Control vector layout:
  // mem_req mem_write i_or_d ir_write pc_write pc_src alu_src_a alu_src_b alu_op
  // reg_write reg_dst mem_to_reg illegal
  localparam logic [15:0] c_FETCH_W  = 16'b1_0_0_0_0_00_0_01_00_0_0_0_0;
  localparam logic [15:0] c_FETCH_R  = 16'b1_0_0_1_1_00_0_01_00_0_0_0_0;
  localparam logic [15:0] c_DECODE   = 16'b0_0_0_0_0_00_0_11_00_0_0_0_0;
  localparam logic [15:0] c_DEC_ILL  = 16'b0_0_0_0_0_00_0_11_00_0_0_0_1;
  localparam logic [15:0] c_MEMADR   = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [15:0] c_MEMREAD  = 16'b1_0_1_0_0_00_0_00_00_0_0_0_0;
  localparam logic [15:0] c_MEMWB    = 16'b0_0_0_0_0_00_0_00_00_1_0_1_0;
  localparam logic [15:0] c_MEMWRITE = 16'b1_1_1_0_0_00_0_00_00_0_0_0_0;
  localparam logic [15:0] c_EXECUTE  = 16'b0_0_0_0_0_00_1_00_10_0_0_0_0;
  localparam logic [15:0] c_ALUWB    = 16'b0_0_0_0_0_00_0_00_00_1_1_0_0;
  localparam logic [15:0] c_BR_Z1    = 16'b0_0_0_0_1_01_1_00_01_0_0_0_0;
  localparam logic [15:0] c_BR_Z0    = 16'b0_0_0_0_0_01_1_00_01_0_0_0_0;
  localparam logic [15:0] c_ADDIEX   = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
  localparam logic [15:0] c_ADDIWB   = 16'b0_0_0_0_0_00_0_00_00_1_0_0_0;
  localparam logic [15:0] c_JUMP     = 16'b0_0_0_0_1_10_0_00_00_0_0_0_0;
  localparam logic [15:0] c_RESET    = 16'b0_0_0_0_0_00_0_01_00_0_0_0_0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic [15:0] w_ctl;
  assign w_ctl = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};

  // One cycle: drive inputs after the falling edge, check settled outputs.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic z, input logic rdy,
                      input logic [3:0] exp_st, input logic [15:0] exp_ctl);
    @(negedge clk);
    reset = rst; opcode = op; zero = z; mem_ready = rdy;
    #1;
    checks++;
    assert (state === exp_st) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
    end
    checks++;
    assert (w_ctl === exp_ctl) else begin
      errors++;
      $error("FAIL %s ctl: got %b expected %b", tag, w_ctl, exp_ctl);
    end
  endtask

  initial begin
    // Reset held for two edges; enables forced low, FETCH selects shown.
    step("rst0", 1'b1, OP_BAD, 1'b1, 1'b1, 4'd0, c_RESET);
    step("rst1", 1'b1, OP_BAD, 1'b1, 1'b1, 4'd0, c_RESET);

    // add
    step("add_f",  1'b0, OP_BAD, 1'b0, 1'b1, 4'd0, c_FETCH_R);
    step("add_d",  1'b0, OP_R,   1'b0, 1'b1, 4'd1, c_DECODE);
    step("add_ex", 1'b0, OP_LW,  1'b0, 1'b1, 4'd6, c_EXECUTE);
    step("add_wb", 1'b0, OP_LW,  1'b0, 1'b1, 4'd7, c_ALUWB);
    // lw (opcode changed after DECODE must be ignored)
    step("lw_f",   1'b0, OP_J,   1'b0, 1'b1, 4'd0, c_FETCH_R);
    step("lw_d",   1'b0, OP_LW,  1'b0, 1'b1, 4'd1, c_DECODE);
    step("lw_ma",  1'b0, OP_SW,  1'b0, 1'b1, 4'd2, c_MEMADR);
    step("lw_mr",  1'b0, OP_SW,  1'b0, 1'b1, 4'd3, c_MEMREAD);
    step("lw_wb",  1'b0, OP_SW,  1'b0, 1'b1, 4'd4, c_MEMWB);
    // sw
    step("sw_f",   1'b0, OP_R,   1'b0, 1'b1, 4'd0, c_FETCH_R);
    step("sw_d",   1'b0, OP_SW,  1'b0, 1'b1, 4'd1, c_DECODE);
    step("sw_ma",  1'b0, OP_LW,  1'b0, 1'b1, 4'd2, c_MEMADR);
    step("sw_mw",  1'b0, OP_LW,  1'b0, 1'b1, 4'd5, c_MEMWRITE);
    // beq taken
    step("beq1_f", 1'b0, OP_R,   1'b0, 1'b1, 4'd0, c_FETCH_R);
    step("beq1_d", 1'b0, OP_BEQ, 1'b0, 1'b1, 4'd1, c_DECODE);
    step("beq1_b", 1'b0, OP_BEQ, 1'b1, 1'b1, 4'd8, c_BR_Z1);
    // addi
    step("addi_f", 1'b0, OP_R,   1'b0, 1'b1, 4'd0, c_FETCH_R);
    step("addi_d", 1'b0, OP_ADDI,1'b0, 1'b1, 4'd1, c_DECODE);
    step("addi_x", 1'b0, OP_ADDI,1'b0, 1'b1, 4'd9, c_ADDIEX);
    step("addi_w", 1'b0, OP_ADDI,1'b0, 1'b1, 4'd10, c_ADDIWB);
    // j
    step("j_f",    1'b0, OP_R,   1'b0, 1'b1, 4'd0, c_FETCH_R);
    step("j_d",    1'b0, OP_J,   1'b0, 1'b1, 4'd1, c_DECODE);
    step("j_j",    1'b0, OP_J,   1'b0, 1'b1, 4'd11, c_JUMP);
    // beq not taken
    step("beq0_f", 1'b0, OP_R,   1'b0, 1'b1, 4'd0, c_FETCH_R);
    step("beq0_d", 1'b0, OP_BEQ, 1'b0, 1'b1, 4'd1, c_DECODE);
    step("beq0_b", 1'b0, OP_BEQ, 1'b0, 1'b1, 4'd8, c_BR_Z0);
    // Fetch with three wait cycles
    step("fst_0",  1'b0, OP_R,   1'b0, 1'b0, 4'd0, c_FETCH_W);
    step("fst_1",  1'b0, OP_R,   1'b0, 1'b0, 4'd0, c_FETCH_W);
    step("fst_2",  1'b0, OP_R,   1'b0, 1'b0, 4'd0, c_FETCH_W);
    step("fst_3",  1'b0, OP_R,   1'b0, 1'b1, 4'd0, c_FETCH_R);
    // Illegal opcode, then FETCH
    step("ill_d",  1'b0, OP_BAD, 1'b0, 1'b1, 4'd1, c_DEC_ILL);
    step("ill_f",  1'b0, OP_BAD, 1'b0, 1'b1, 4'd0, c_FETCH_R);
    // sw with two wait cycles
    step("sww_d",  1'b0, OP_SW,  1'b0, 1'b1, 4'd1, c_DECODE);
    step("sww_ma", 1'b0, OP_R,   1'b0, 1'b1, 4'd2, c_MEMADR);
    step("sww_w0", 1'b0, OP_R,   1'b0, 1'b0, 4'd5, c_MEMWRITE);
    step("sww_w1", 1'b0, OP_R,   1'b0, 1'b0, 4'd5, c_MEMWRITE);
    step("sww_w2", 1'b0, OP_R,   1'b0, 1'b1, 4'd5, c_MEMWRITE);
    step("sww_f",  1'b0, OP_R,   1'b0, 1'b1, 4'd0, c_FETCH_R);
    // lw stalled in MEMREAD, then reset mid-stall
    step("rms_d",  1'b0, OP_LW,  1'b0, 1'b1, 4'd1, c_DECODE);
    step("rms_ma", 1'b0, OP_LW,  1'b0, 1'b1, 4'd2, c_MEMADR);
    step("rms_mr", 1'b0, OP_LW,  1'b0, 1'b0, 4'd3, c_MEMREAD);
    step("rms_rs", 1'b1, OP_LW,  1'b0, 1'b0, 4'd3, c_RESET);
    step("rms_f",  1'b0, OP_LW,  1'b0, 1'b0, 4'd0, c_FETCH_W);
    step("rms_f2", 1'b0, OP_LW,  1'b0, 1'b1, 4'd0, c_FETCH_R);
    step("rms_d2", 1'b0, OP_R,   1'b0, 1'b1, 4'd1, c_DECODE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
